cordic_exp_scheduler: RTL and testbench
=======================================

# cordic_exp_scheduler

Sequential front-end that shares one combinational hyperbolic CORDIC core (16-bit angle in, cosh/sinh out) among several softmax lanes. It arbitrates requesters round-robin, registers the winning angle into the core, captures cosh/sinh one cycle later, forms exp = cosh + sinh, and returns the result tagged with the requester ID over a valid/ready output. The block sits between the per-lane softmax control and the single shared CORDIC instance in the softmax datapath.

## Interface
- N_REQ, 4, number of requesters (≥2)
- LEN, 16, angle and cosh/sinh width (signed, 2 integer bits, LEN-2 fraction bits)
- ID_W, $clog2(N_REQ), requester ID width

- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  per-requester request valid
- req_angle  in  N_REQ*LEN  packed angles; requester i uses bits [i*LEN +: LEN]
- req_ready  out  N_REQ  one-hot accept strobe
- core_angle  out  LEN  registered angle to the external CORDIC core
- core_cosh  in  LEN  core cosh output (combinational from core_angle)
- core_sinh  in  LEN  core sinh output
- out_valid  out  1  result valid
- out_ready  in  1  downstream ready
- out_id  out  ID_W  requester that issued the result
- out_cosh  out  LEN  captured cosh
- out_sinh  out  LEN  captured sinh
- out_exp  out  LEN+1  signed cosh + sinh, both sign-extended
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, EVAL, OUT.
- IDLE: if any req_valid, grant g = first set bit at or after rr_ptr+1 (mod N_REQ); req_ready[g]=1 this cycle; at edge latch core_angle←req_angle[g], id_q←g, rr_ptr←g, go EVAL. No valid: stay.
- EVAL: core settles on core_angle; at edge capture out_cosh/out_sinh/out_exp/out_id, out_valid←1, go OUT. No grant in EVAL.
- OUT: out_valid held, data stable. If out_ready=0: stay, req_ready=0. If out_ready=1 and any req_valid: grant as in IDLE the same cycle, out_valid←0, go EVAL (back-to-back). If out_ready=1 and no valid: out_valid←0, go IDLE.
- req_ready is combinational from state, out_ready, req_valid, rr_ptr; at most one bit set; never set for a requester whose req_valid is 0.
- Requesters hold req_valid and req_angle stable until accepted; dropping valid before accept is legal and withdraws the request.
- rr_ptr changes only on a grant; a lone requester is granted every opportunity.
- out_exp: signed add of sign-extended cosh and sinh; no saturation (LEN+1 bits cannot overflow).

## Timing
- Reset (async assert, sync-safe deassert handled upstream): state IDLE, rr_ptr=N_REQ-1 (requester 0 highest first), core_angle=0, out_valid=0, out_id=0, out_cosh=0, out_sinh=0, out_exp=0, req_ready=0, busy=0.
- Latency: accept in cycle c → out_valid high in cycle c+2.
- Throughput: one result per 2 cycles with out_ready held high; slower under backpressure.
- Reset mid-operation discards in-flight angle/result; no output after release until a new accept.
- Core assumed to settle within one clk period; no other combinational path from req_* to out_*.

## Structure
- Package cordic_sched_pkg: state enum (IDLE, EVAL, OUT), default LEN, ID width helper.
- One sub-module rr_arbiter (N_REQ request vector + pointer in, one-hot grant + encoded index out, purely combinational); pointer register stays in the scheduler.
- CORDIC core instantiated by the parent, connected via core_* ports; benches use a behavioral core stub.

## Test plan
- Reset: drive rst_n=0 mid-EVAL with angle 16'h2000 pending → all outputs 0 immediately, no out_valid after release.
- Single request: requester 2, angle 16'h1000, stub cosh=angle+1, sinh=angle → out_valid at c+2, out_id=2, out_cosh=16'h1001, out_sinh=16'h1000, out_exp=17'h02001.
- Round-robin: all four valid continuously, out_ready=1 → grant order 0,1,2,3,0,…, one result per 2 cycles.
- Backpressure: out_ready=0 for 5 cycles in OUT → outputs stable, req_ready all 0, rr_ptr unchanged; release → next grant same cycle.
- Sign extension: stub cosh=16'h8000, sinh=16'h8000 → out_exp=17'h10000.
- Withdrawn request: requester 1 drops valid before grant while requester 3 valid → requester 3 granted, requester 1 never acknowledged.

Source files
------------

// File: rtl/cordic_exp_scheduler_pkg.sv
// rtl/cordic_exp_scheduler_pkg.sv - shared types and sizing helpers for the CORDIC exp scheduler
package cordic_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        OUT  = 2'd2
    } sched_state_t;

    localparam int DEFAULT_N_REQ = 4;
    localparam int DEFAULT_LEN   = 16;

    // Width of a requester index; never below one bit so ports stay legal.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cordic_exp_scheduler_if.sv
// rtl/cordic_exp_scheduler_if.sv - request/result handshake bundle between softmax lanes and the scheduler
interface cordic_exp_scheduler_if
    import cordic_sched_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int LEN   = DEFAULT_LEN,
    parameter int ID_W  = id_width(N_REQ)
) ();

    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ*LEN-1:0] req_angle;
    logic [N_REQ-1:0]     req_ready;

    logic                 out_valid;
    logic                 out_ready;
    logic [ID_W-1:0]      out_id;
    logic [LEN-1:0]       out_cosh;
    logic [LEN-1:0]       out_sinh;
    logic [LEN:0]         out_exp;

    modport master (
        output req_valid, req_angle, out_ready,
        input  req_ready, out_valid, out_id, out_cosh, out_sinh, out_exp
    );

    modport slave (
        input  req_valid, req_angle, out_ready,
        output req_ready, out_valid, out_id, out_cosh, out_sinh, out_exp
    );

endinterface

// File: rtl/cordic_exp_scheduler_rr_arbiter.sv
// rtl/cordic_exp_scheduler_rr_arbiter.sv - combinational round-robin pick starting just after ptr
module rr_arbiter
    import cordic_sched_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int ID_W  = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    int cand;

    // Scan ptr+1 .. ptr+N_REQ so the last winner is visited last.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(ptr) + k) % N_REQ;
            if (!any && req[ID_W'(cand)]) begin
                any                = 1'b1;
                grant[ID_W'(cand)] = 1'b1;
                idx                = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/cordic_exp_scheduler.sv
// rtl/cordic_exp_scheduler.sv - shares one combinational hyperbolic CORDIC core among softmax lanes
module cordic_exp_scheduler
    import cordic_sched_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int LEN   = DEFAULT_LEN,
    parameter int ID_W  = id_width(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cordic_exp_scheduler_if.slave  bus,
    output logic [LEN-1:0]         core_angle,
    input  logic [LEN-1:0]         core_cosh,
    input  logic [LEN-1:0]         core_sinh,
    output logic                   busy
);

    sched_state_t     state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  id_q;

    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_idx;
    logic             grant_any;
    logic             grant_en;
    logic             take;
    logic [LEN-1:0]   sel_angle;
    logic [LEN:0]     exp_sum;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    // A grant slot exists in IDLE, or in OUT once the held result is taken.
    assign grant_en      = (state == IDLE) || ((state == OUT) && bus.out_ready);
    assign bus.req_ready = grant_en ? grant : '0;
    assign take          = grant_en && grant_any;
    assign sel_angle     = bus.req_angle[int'(grant_idx)*LEN +: LEN];
    assign busy          = (state != IDLE);

    assign exp_sum = {core_cosh[LEN-1], core_cosh} + {core_sinh[LEN-1], core_sinh};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= ID_W'(N_REQ - 1);
            id_q         <= '0;
            core_angle   <= '0;
            bus.out_valid <= 1'b0;
            bus.out_id   <= '0;
            bus.out_cosh <= '0;
            bus.out_sinh <= '0;
            bus.out_exp  <= '0;
        end else begin
            if (take) begin
                core_angle <= sel_angle;
                id_q       <= grant_idx;
                rr_ptr     <= grant_idx;
            end
            case (state)
                IDLE: begin
                    if (take) state <= EVAL;
                end
                EVAL: begin
                    bus.out_cosh  <= core_cosh;
                    bus.out_sinh  <= core_sinh;
                    bus.out_exp   <= exp_sum;
                    bus.out_id    <= id_q;
                    bus.out_valid <= 1'b1;
                    state         <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= take ? EVAL : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_exp_scheduler.sv
// tb/tb_cordic_exp_scheduler.sv - directed bench for cordic_exp_scheduler with a behavioral core stub
module tb_cordic_exp_scheduler;
    import cordic_sched_pkg::*;

    localparam int N_REQ = 4;
    localparam int LEN   = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [LEN-1:0] core_angle;
    logic [LEN-1:0] core_cosh;
    logic [LEN-1:0] core_sinh;
    logic           busy;
    logic           stub_mode;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cordic_exp_scheduler_if #(.N_REQ(N_REQ), .LEN(LEN)) bus ();

    cordic_exp_scheduler #(.N_REQ(N_REQ), .LEN(LEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .core_angle (core_angle),
        .core_cosh  (core_cosh),
        .core_sinh  (core_sinh),
        .busy       (busy)
    );

    always_comb begin
        core_cosh = stub_mode ? 16'h8000 : core_angle + 16'd1;
        core_sinh = stub_mode ? 16'h8000 : core_angle;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] a;
        int g;

        rst_n         = 1'b0;
        stub_mode     = 1'b0;
        bus.req_valid = '0;
        bus.req_angle = '0;
        bus.out_ready = 1'b0;
        step; step;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_core_angle", 32'(core_angle), 32'd0);
        chk("rst_out_id", 32'(bus.out_id), 32'd0);
        chk("rst_out_exp", 32'(bus.out_exp), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        step;

        // single request from lane 2
        bus.req_angle[2*LEN +: LEN] = 16'h1000;
        bus.req_valid = 4'b0100;
        #1 chk("single_grant", 32'(bus.req_ready), 32'h4);
        step;
        bus.req_valid = '0;
        chk("single_c1_valid", 32'(bus.out_valid), 32'd0);
        chk("single_core_angle", 32'(core_angle), 32'h1000);
        chk("single_busy", 32'(busy), 32'd1);
        step;
        chk("single_c2_valid", 32'(bus.out_valid), 32'd1);
        chk("single_id", 32'(bus.out_id), 32'd2);
        chk("single_cosh", 32'(bus.out_cosh), 32'h1001);
        chk("single_sinh", 32'(bus.out_sinh), 32'h1000);
        chk("single_exp", 32'(bus.out_exp), 32'h02001);

        // backpressure with all lanes waiting
        for (int i = 0; i < N_REQ; i++) bus.req_angle[i*LEN +: LEN] = 16'(16'h0100 * (i + 1));
        bus.req_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_exp_stable", 32'(bus.out_exp), 32'h02001);
            step;
        end
        bus.out_ready = 1'b1;
        #1 chk("bp_release_grant", 32'(bus.req_ready), 32'h8);
        step;
        chk("bp_eval_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_core_angle", 32'(core_angle), 32'h0400);
        step;
        chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_out_id", 32'(bus.out_id), 32'd3);
        chk("bp_out_exp", 32'(bus.out_exp), 32'h0801);

        // round-robin, back-to-back results
        for (int k = 0; k < 5; k++) begin
            g = k % N_REQ;
            a = 16'(16'h0100 * (g + 1));
            #1 chk("rr_grant", 32'(bus.req_ready), 32'd1 << g);
            step;
            chk("rr_eval_valid", 32'(bus.out_valid), 32'd0);
            chk("rr_core_angle", 32'(core_angle), 32'(a));
            step;
            chk("rr_out_valid", 32'(bus.out_valid), 32'd1);
            chk("rr_out_id", 32'(bus.out_id), 32'(g));
            chk("rr_out_exp", 32'(bus.out_exp), 32'(a) * 2 + 1);
        end

        // lane 1 withdraws before it can be granted
        bus.out_ready = 1'b0;
        bus.req_valid = 4'b1010;
        #1 chk("wd_hold", 32'(bus.req_ready), 32'd0);
        step;
        bus.req_valid = 4'b1000;
        bus.out_ready = 1'b1;
        #1 chk("wd_grant", 32'(bus.req_ready), 32'h8);
        step;
        bus.req_valid = '0;
        chk("wd_core_angle", 32'(core_angle), 32'h0400);
        step;
        chk("wd_out_id", 32'(bus.out_id), 32'd3);
        #1 chk("wd_no_ready", 32'(bus.req_ready), 32'd0);
        step;
        chk("wd_idle_busy", 32'(busy), 32'd0);
        chk("wd_idle_valid", 32'(bus.out_valid), 32'd0);

        // sign extension of the cosh + sinh sum
        stub_mode     = 1'b1;
        bus.req_valid = 4'b0001;
        #1 chk("sx_grant", 32'(bus.req_ready), 32'h1);
        step;
        bus.req_valid = '0;
        step;
        chk("sx_cosh", 32'(bus.out_cosh), 32'h8000);
        chk("sx_exp", 32'(bus.out_exp), 32'h10000);
        step;
        stub_mode = 1'b0;
        chk("sx_idle_busy", 32'(busy), 32'd0);

        // asynchronous reset while an angle is in EVAL
        bus.req_angle[0 +: LEN] = 16'h2000;
        bus.req_valid = 4'b0001;
        #1 chk("rm_grant", 32'(bus.req_ready), 32'h1);
        step;
        bus.req_valid = '0;
        chk("rm_core_angle", 32'(core_angle), 32'h2000);
        chk("rm_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rm_core_angle_clr", 32'(core_angle), 32'd0);
        chk("rm_busy_clr", 32'(busy), 32'd0);
        chk("rm_valid_clr", 32'(bus.out_valid), 32'd0);
        chk("rm_cosh_clr", 32'(bus.out_cosh), 32'd0);
        chk("rm_exp_clr", 32'(bus.out_exp), 32'd0);
        chk("rm_ready_clr", 32'(bus.req_ready), 32'd0);
        step; step;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step;
            chk("rm_post_valid", 32'(bus.out_valid), 32'd0);
            chk("rm_post_busy", 32'(busy), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
